// File: rtl/tomasula_types.sv
// Shared Tomasulo datapath types: common-data-bus broadcast slot and default machine sizes.
// Pure declarations; no latency and no flow control of its own.
package tomasula_types;

    localparam int NUM_REQ_DEF   = 6;
    localparam int NUM_PORTS_DEF = 2;
    localparam int TAG_W_DEF     = 3;
    localparam int DATA_W        = 32;

    typedef struct packed {
        logic                 valid;
        logic [TAG_W_DEF-1:0] tag;
        logic [DATA_W-1:0]    data;
    } cdb_slot_t;

    // Position 'off' steps after 'base' on a ring of n requesters.
    function automatic int wrap_idx(input int base, input int off, input int n);
        return (base + off) % n;
    endfunction

endpackage

// File: rtl/rr_picker.sv
// Rotating first-P picker: scans req upward from ptr and grants the first P set bits.
// Purely combinational; last_idx is the final grant in scan order (0 when nothing granted).
// No backpressure of its own; callers qualify gnt with their own stall conditions.
module rr_picker
    import tomasula_types::*;
#(
    parameter int N  = NUM_REQ_DEF,
    parameter int P  = NUM_PORTS_DEF,
    parameter int PW = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]  req,
    input  logic [PW-1:0] ptr,
    output logic [N-1:0]  gnt,
    output logic [PW-1:0] last_idx
);

    always_comb begin
        int cnt;
        int idx;
        gnt      = '0;
        last_idx = '0;
        cnt      = 0;
        idx      = 0;
        for (int o = 0; o < N; o++) begin
            idx = wrap_idx(int'(ptr), o, N);
            if (req[idx] && (cnt < P)) begin
                gnt[idx] = 1'b1;
                last_idx = PW'(idx);
                cnt      = cnt + 1;
            end
        end
    end

endmodule

// File: rtl/cdb_arbiter.sv
// Common-data-bus arbiter: grants up to NUM_PORTS producers per cycle round-robin, broadcasts them.
// Latency: req_ready is combinational; the matching cdb slot is valid one cycle after the grant.
// Backpressure: an ungranted producer holds its result; flush_ip or rst forces all req_ready low.
// Build option CDB_ARB_LSQ_PRIORITY_EN: the LSQ (last requester) always owns slot 0 when valid.
module cdb_arbiter
    import tomasula_types::*;
#(
    parameter int NUM_REQ   = NUM_REQ_DEF,
    parameter int NUM_PORTS = NUM_PORTS_DEF,
    parameter int TAG_W     = TAG_W_DEF
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       flush_ip,
    input  logic [NUM_REQ-1:0]         req_valid,
    input  logic [NUM_REQ*TAG_W-1:0]   req_tag,
    input  logic [NUM_REQ*DATA_W-1:0]  req_data,
    output logic [NUM_REQ-1:0]         req_ready,
    output logic [NUM_PORTS-1:0]       cdb_valid,
    output logic [NUM_PORTS*TAG_W-1:0] cdb_tag,
    output logic [NUM_PORTS*DATA_W-1:0] cdb_data,
    output logic [15:0]                stall_cnt
);

    localparam int PW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    logic [PW-1:0]        rr_ptr;
    logic [NUM_REQ-1:0]   gnt;
    logic [NUM_REQ-1:0]   rr_gnt;
    logic [PW-1:0]        rr_last;
    logic                 rr_hit;
    logic                 stall_evt;

    logic [NUM_PORTS-1:0] slot_use;
    logic [PW-1:0]        slot_sel [NUM_PORTS];
    cdb_slot_t            slot_nxt [NUM_PORTS];
    cdb_slot_t            slot_q   [NUM_PORTS];

`ifdef CDB_ARB_LSQ_PRIORITY_EN
    localparam int LSQ = NUM_REQ - 1;

    logic                 lsq_vld;
    logic [NUM_REQ-1:0]   rr_req;
    logic [NUM_REQ-1:0]   gnt_full;
    logic [NUM_REQ-1:0]   gnt_short;
    logic [PW-1:0]        last_full;
    logic [PW-1:0]        last_short;

    always_comb begin
        rr_req      = req_valid;
        rr_req[LSQ] = 1'b0;
    end

    assign lsq_vld = req_valid[LSQ];

    // Two pickers: all ports for the ring, or one port fewer once the LSQ claims slot 0.
    rr_picker #(.N(NUM_REQ), .P(NUM_PORTS), .PW(PW)) u_pick_full (
        .req      (rr_req),
        .ptr      (rr_ptr),
        .gnt      (gnt_full),
        .last_idx (last_full)
    );

    rr_picker #(.N(NUM_REQ), .P(NUM_PORTS - 1), .PW(PW)) u_pick_short (
        .req      (rr_req),
        .ptr      (rr_ptr),
        .gnt      (gnt_short),
        .last_idx (last_short)
    );

    always_comb begin
        gnt     = gnt_full;
        rr_gnt  = gnt_full;
        rr_last = last_full;
        if (lsq_vld) begin
            rr_gnt   = gnt_short;
            rr_last  = last_short;
            gnt      = gnt_short;
            gnt[LSQ] = 1'b1;
        end
    end
`else
    rr_picker #(.N(NUM_REQ), .P(NUM_PORTS), .PW(PW)) u_pick (
        .req      (req_valid),
        .ptr      (rr_ptr),
        .gnt      (rr_gnt),
        .last_idx (rr_last)
    );

    assign gnt = rr_gnt;
`endif

    assign rr_hit    = |rr_gnt;
    assign req_ready = (flush_ip || rst) ? '0 : gnt;
    assign stall_evt = !flush_ip && (|(req_valid & ~req_ready));

    // Slot k carries the k-th grant in scan order, so re-walk the ring from rr_ptr.
    always_comb begin
        int k;
        int idx;
        slot_use = '0;
        for (int s = 0; s < NUM_PORTS; s++) begin
            slot_sel[s] = '0;
        end
        k   = 0;
        idx = 0;
`ifdef CDB_ARB_LSQ_PRIORITY_EN
        if (lsq_vld) begin
            slot_use[0] = 1'b1;
            slot_sel[0] = PW'(LSQ);
            k           = 1;
        end
`endif
        for (int o = 0; o < NUM_REQ; o++) begin
            idx = wrap_idx(int'(rr_ptr), o, NUM_REQ);
            if (rr_gnt[idx] && (k < NUM_PORTS)) begin
                slot_use[k] = 1'b1;
                slot_sel[k] = PW'(idx);
                k           = k + 1;
            end
        end
    end

    always_comb begin
        for (int s = 0; s < NUM_PORTS; s++) begin
            slot_nxt[s].valid = slot_use[s] && !flush_ip;
            slot_nxt[s].tag   = TAG_W_DEF'(req_tag[int'(slot_sel[s])*TAG_W +: TAG_W]);
            slot_nxt[s].data  = req_data[int'(slot_sel[s])*DATA_W +: DATA_W];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int s = 0; s < NUM_PORTS; s++) begin
                slot_q[s] <= '0;
            end
            rr_ptr    <= '0;
            stall_cnt <= '0;
        end else begin
            for (int s = 0; s < NUM_PORTS; s++) begin
                slot_q[s] <= slot_nxt[s];
            end
            if (flush_ip) begin
                rr_ptr <= '0;
            end else if (rr_hit) begin
                rr_ptr <= PW'(wrap_idx(int'(rr_last), 1, NUM_REQ));
            end
            if (stall_evt && (stall_cnt != 16'hFFFF)) begin
                stall_cnt <= stall_cnt + 16'd1;
            end
        end
    end

    for (genvar s = 0; s < NUM_PORTS; s++) begin : g_out
        assign cdb_valid[s]                   = slot_q[s].valid;
        assign cdb_tag[s*TAG_W +: TAG_W]      = TAG_W'(slot_q[s].tag);
        assign cdb_data[s*DATA_W +: DATA_W]   = slot_q[s].data;
    end

endmodule
